// File: rtl/kernel_stream_ctrl.sv
// Run controller for one streaming kernel: admits nitems words into the kernel,
// collects nitems results for the sink, pulses done, and flags a stalled drain.
module kernel_stream_ctrl #(
  parameter int STREAMW = 34,
  parameter int CNTW    = 32,
  parameter int TOW     = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [CNTW-1:0]    nitems,
  input  logic [TOW-1:0]     timeout,
  output logic               busy,
  output logic               done,
  output logic               err,
  input  logic               src_valid,
  input  logic [STREAMW-1:0] src_data,
  output logic               src_ready,
  output logic               k_ivalid,
  output logic [STREAMW-1:0] k_in1,
  input  logic               k_iready,
  input  logic               k_ovalid,
  input  logic [STREAMW-1:0] k_out1,
  output logic               k_oready,
  output logic               snk_valid,
  output logic [STREAMW-1:0] snk_data,
  input  logic               snk_ready,
  output logic [CNTW-1:0]    in_count,
  output logic [CNTW-1:0]    out_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE,
    S_ERR
  } state_t;

  state_t          state;
  logic [CNTW-1:0] nitems_r;
  logic [TOW-1:0]  timeout_r;
  logic [TOW-1:0]  wd;

  logic            in_open;
  logic            out_open;
  logic            in_hs;
  logic            out_hs;
  logic [CNTW-1:0] in_next;
  logic [CNTW-1:0] out_next;
  logic [TOW-1:0]  wd_inc;

  // Gates depend only on registered state and counters, so the data path adds no latency.
  assign in_open   = (state == S_RUN) && (in_count < nitems_r);
  assign out_open  = ((state == S_RUN) || (state == S_DRAIN)) && (out_count < nitems_r);

  assign k_ivalid  = src_valid & in_open;
  assign src_ready = k_iready & in_open;
  assign k_in1     = src_data;

  assign snk_valid = k_ovalid & out_open;
  assign k_oready  = snk_ready & out_open;
  assign snk_data  = k_out1;

  assign in_hs     = k_ivalid & k_iready;
  assign out_hs    = snk_valid & snk_ready;
  assign in_next   = in_count + CNTW'(in_hs);
  assign out_next  = out_count + CNTW'(out_hs);
  assign wd_inc    = wd + TOW'(1);

  // NOTE: all state below uses non-blocking assignments so every branch sees the
  // pre-edge values of state and counters, exactly as the combinational gates do.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      in_count  <= '0;
      out_count <= '0;
      wd        <= '0;
      nitems_r  <= '0;
      timeout_r <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            nitems_r  <= nitems;
            timeout_r <= timeout;
            in_count  <= '0;
            out_count <= '0;
            err       <= 1'b0;
            wd        <= '0;
            if (nitems != '0) begin
              state <= S_RUN;
              busy  <= 1'b1;
            end else begin
              state <= S_DONE;
              done  <= 1'b1;
            end
          end
        end

        S_RUN: begin
          in_count  <= in_next;
          out_count <= out_next;
          wd        <= '0;
          if (in_next == nitems_r) begin
            if (out_next == nitems_r) begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state <= S_DRAIN;
            end
          end
        end

        S_DRAIN: begin
          out_count <= out_next;
          if (out_next == nitems_r) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (out_hs) begin
            wd <= '0;
          end else begin
            // Saturate so a disabled watchdog never wraps back through small values.
            wd <= (wd == '1) ? wd : wd_inc;
            if ((timeout_r != '0) && (wd_inc == timeout_r)) begin
              state <= S_ERR;
              busy  <= 1'b0;
              err   <= 1'b1;
            end
          end
        end

        S_DONE: state <= S_IDLE;

        S_ERR:  state <= S_IDLE;

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_kernel_stream_ctrl.sv
// Bench for kernel_stream_ctrl: a vector table, scripted corner cases, then
// random traffic against a count-based reference model and a 1-cycle kernel model.
module tb_kernel_stream_ctrl;

  localparam int SW = 34;
  localparam int CW = 32;
  localparam int TW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [CW-1:0] nitems;
  logic [TW-1:0] timeout;
  logic          busy, done, err;
  logic          src_valid, src_ready;
  logic [SW-1:0] src_data;
  logic          k_ivalid, k_iready, k_ovalid, k_oready;
  logic [SW-1:0] k_in1, k_out1;
  logic          snk_valid, snk_ready;
  logic [SW-1:0] snk_data;
  logic [CW-1:0] in_count, out_count;

  kernel_stream_ctrl #(.STREAMW(SW), .CNTW(CW), .TOW(TW)) dut (
    .clk(clk), .rst(rst), .start(start), .nitems(nitems), .timeout(timeout),
    .busy(busy), .done(done), .err(err),
    .src_valid(src_valid), .src_data(src_data), .src_ready(src_ready),
    .k_ivalid(k_ivalid), .k_in1(k_in1), .k_iready(k_iready),
    .k_ovalid(k_ovalid), .k_out1(k_out1), .k_oready(k_oready),
    .snk_valid(snk_valid), .snk_data(snk_data), .snk_ready(snk_ready),
    .in_count(in_count), .out_count(out_count)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [SW-1:0] rand_word();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[SW-1:0];
  endfunction

  // Reference model: run bookkeeping in plain counts and flags.
  bit            m_active, m_done, m_errc, m_err;
  logic [CW-1:0] m_in, m_out, m_n;
  logic [TW-1:0] m_to;
  int            m_stall;

  // Kernel model (1-cycle latency, result = input + 1) and sink scoreboard of raw source words.
  logic [SW-1:0] kq[$];
  logic [SW-1:0] sb[$];
  bit            kov_en;

  int cyc = 0;
  int st_in, st_out, st_done, st_done_cyc, st_last_out, st_busy, st_err_cyc, st_kor_bad;

  task automatic model_reset();
    m_active = 0; m_done = 0; m_errc = 0; m_err = 0;
    m_in = '0; m_out = '0; m_n = '0; m_to = '0; m_stall = 0;
    kq.delete(); sb.delete();
  endtask

  task automatic clr_stats();
    st_in = 0; st_out = 0; st_done = 0; st_done_cyc = -1; st_last_out = -1;
    st_busy = 0; st_err_cyc = -1; st_kor_bad = 0;
  endtask

  task automatic model_step(input bit in_hs, input bit out_hs);
    bit idle, was_drain;
    idle      = !m_active && !m_done && !m_errc;
    was_drain = m_active && (m_in == m_n);
    m_done = 0;
    m_errc = 0;
    if (rst) begin
      model_reset();
    end else if (idle) begin
      if (start) begin
        m_err = 0; m_in = '0; m_out = '0; m_n = nitems; m_to = timeout; m_stall = 0;
        kq.delete(); sb.delete();
        if (nitems == '0) m_done = 1;
        else m_active = 1;
      end
    end else if (m_active) begin
      m_in  = m_in + CW'(in_hs);
      m_out = m_out + CW'(out_hs);
      if (m_in == m_n && m_out == m_n) begin
        m_active = 0;
        m_done   = 1;
      end else if (was_drain) begin
        if (out_hs) m_stall = 0;
        else begin
          m_stall++;
          if (m_to != '0 && m_stall == int'(m_to)) begin
            m_active = 0; m_errc = 1; m_err = 1;
          end
        end
      end else begin
        m_stall = 0;
      end
    end
  endtask

  // One clock cycle: inputs already driven at posedge+1, outputs sampled at the negedge.
  task automatic run_cycle();
    bit m_iopen, m_oopen, in_hs, out_hs;
    logic [SW-1:0] exp_w;
    k_ovalid = kov_en && (kq.size() > 0);
    k_out1   = (kq.size() > 0) ? kq[0] : '0;
    #4;
    m_iopen = m_active && (m_in < m_n);
    m_oopen = m_active && (m_out < m_n);
    check("busy", busy, m_active);
    check("done", done, m_done);
    check("err", err, m_err);
    check("src_ready", src_ready, k_iready & m_iopen);
    check("k_ivalid", k_ivalid, src_valid & m_iopen);
    check("k_oready", k_oready, snk_ready & m_oopen);
    check("snk_valid", snk_valid, k_ovalid & m_oopen);
    check("in_count", in_count, m_in);
    check("out_count", out_count, m_out);
    check("k_in1", k_in1, src_data);
    check("snk_data", snk_data, k_out1);
    in_hs  = src_valid && k_iready && m_iopen;
    out_hs = k_ovalid && snk_ready && m_oopen;
    if (k_ivalid && k_iready) st_in++;
    if (snk_valid && snk_ready) begin st_out++; st_last_out = cyc; end
    if (done) begin st_done++; st_done_cyc = cyc; end
    if (busy) st_busy++;
    if (err && st_err_cyc < 0) st_err_cyc = cyc;
    if (k_oready && !snk_ready) st_kor_bad++;
    if (out_hs) begin
      if (sb.size() == 0) check("sink_underflow", 1, 0);
      else begin
        exp_w = sb.pop_front() + SW'(1);
        check("sink_order", snk_data, exp_w);
      end
      void'(kq.pop_front());
    end
    if (in_hs) begin
      sb.push_back(src_data);
      kq.push_back(k_in1 + SW'(1));
      src_data = rand_word();
    end
    model_step(in_hs, out_hs);
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1; start = 0; nitems = '0; timeout = '0;
    src_valid = 0; k_iready = 0; snk_ready = 0; k_ovalid = 0; kov_en = 0;
    src_data = rand_word(); k_out1 = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 0;
    model_reset();
    clr_stats();
  endtask

  // Runs cycles until done or err is seen, up to a budget; the caller has issued start already.
  task automatic run_until_end(input int budget, input bit stop_on_err);
    for (int i = 0; i < budget; i++) begin
      run_cycle();
      if (st_done > 0 || (stop_on_err && st_err_cyc >= 0)) break;
    end
  endtask

  task automatic issue_start(input logic [CW-1:0] n, input logic [TW-1:0] to, output int s);
    start = 1; nitems = n; timeout = to; s = cyc;
    run_cycle();
    start = 0;
  endtask

  typedef struct {
    logic          start;
    logic [CW-1:0] nitems;
    logic [3:0]    ins;    // {src_valid, k_iready, k_ovalid, snk_ready}
    logic [5:0]    flags;  // {busy, done, src_ready, k_ivalid, k_oready, snk_valid}
    logic [CW-1:0] exp_in;
    logic [CW-1:0] exp_out;
    logic          chk_cnt;
  } vec_t;

  function automatic vec_t mk(logic st, logic [CW-1:0] n, logic [3:0] ins, logic [5:0] fl,
                              logic [CW-1:0] ei, logic [CW-1:0] eo, logic cc);
    vec_t v;
    v.start = st; v.nitems = n; v.ins = ins; v.flags = fl;
    v.exp_in = ei; v.exp_out = eo; v.chk_cnt = cc;
    return v;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    vec_t tbl[11];
    int s;

    do_reset();

    // Reset state with every upstream/downstream signal asserted.
    src_valid = 1; k_iready = 1; snk_ready = 1; k_ovalid = 1;
    #4;
    check("reset_flags", {busy, done, err, src_ready, k_ivalid, k_oready, snk_valid}, 7'b0);
    check("reset_in_count", in_count, 0);
    check("reset_out_count", out_count, 0);
    @(posedge clk);
    #1;

    // Hand-derived cycle vectors: a 2-item run, an ignored start in DONE, then a zero-count start.
    tbl[0]  = mk(1, 2, 4'b1101, 6'b000000, 0, 0, 1);
    tbl[1]  = mk(0, 0, 4'b1101, 6'b101110, 0, 0, 1);
    tbl[2]  = mk(0, 0, 4'b1011, 6'b100111, 1, 0, 1);
    tbl[3]  = mk(0, 0, 4'b0110, 6'b101001, 1, 1, 1);
    tbl[4]  = mk(0, 0, 4'b1101, 6'b101110, 1, 1, 1);
    tbl[5]  = mk(0, 0, 4'b1111, 6'b100011, 2, 1, 1);
    tbl[6]  = mk(1, 3, 4'b1111, 6'b010000, 2, 2, 1);
    tbl[7]  = mk(0, 0, 4'b1111, 6'b000000, 2, 2, 1);
    tbl[8]  = mk(1, 0, 4'b1111, 6'b000000, 2, 2, 1);
    tbl[9]  = mk(0, 0, 4'b1111, 6'b010000, 0, 0, 0);
    tbl[10] = mk(0, 0, 4'b1111, 6'b000000, 0, 0, 0);
    timeout = '0;
    for (int i = 0; i < 11; i++) begin
      start = tbl[i].start;
      nitems = tbl[i].nitems;
      {src_valid, k_iready, k_ovalid, snk_ready} = tbl[i].ins;
      src_data = rand_word();
      k_out1 = rand_word();
      #4;
      check($sformatf("vec%0d_flags", i), {busy, done, src_ready, k_ivalid, k_oready, snk_valid}, tbl[i].flags);
      if (tbl[i].chk_cnt) begin
        check($sformatf("vec%0d_in_count", i), in_count, tbl[i].exp_in);
        check($sformatf("vec%0d_out_count", i), out_count, tbl[i].exp_out);
      end
      @(posedge clk);
      #1;
    end

    // Basic run: 4 items, no stalls.
    do_reset();
    src_valid = 1; k_iready = 1; snk_ready = 1; kov_en = 1;
    issue_start(4, 0, s);
    run_until_end(30, 0);
    run_cycle(); run_cycle();
    check("basic_in_hs", st_in, 4);
    check("basic_out_hs", st_out, 4);
    check("basic_done_pulses", st_done, 1);
    check("basic_done_gap", st_done_cyc - st_last_out, 1);
    check("basic_done_cycle", st_done_cyc - s, 6);
    check("basic_in_count", in_count, 4);
    check("basic_out_count", out_count, 4);

    // Over-supply: source offers 6 words, only 3 admitted.
    do_reset();
    k_iready = 1; snk_ready = 1; kov_en = 1; src_valid = 1;
    issue_start(3, 0, s);
    for (int i = 0; i < 30; i++) begin
      src_valid = (st_in < 6);
      run_cycle();
      if (st_done > 0) break;
    end
    check("over_in_hs", st_in, 3);
    check("over_busy_cycles", st_busy, 4);
    check("over_done_cycle", st_done_cyc - s, 5);
    check("over_in_count", in_count, 3);

    // Back-pressure: snk_ready 1,0,0 repeating from the first RUN cycle.
    do_reset();
    src_valid = 1; k_iready = 1; kov_en = 1;
    issue_start(5, 0, s);
    for (int i = 0; i < 60; i++) begin
      snk_ready = ((cyc - s - 1) % 3 == 0);
      run_cycle();
      if (st_done > 0) break;
    end
    check("bp_out_hs", st_out, 5);
    check("bp_kor_mirror", st_kor_bad, 0);
    check("bp_done_pulses", st_done, 1);
    check("bp_done_gap", st_done_cyc - st_last_out, 1);
    check("bp_out_count", out_count, 5);

    // Zero count.
    do_reset();
    src_valid = 1; k_iready = 1; snk_ready = 1; kov_en = 1;
    issue_start(0, 0, s);
    for (int i = 0; i < 4; i++) run_cycle();
    check("zero_done_pulses", st_done, 1);
    check("zero_done_cycle", st_done_cyc - s, 1);
    check("zero_busy_cycles", st_busy, 0);
    check("zero_handshakes", st_in + st_out, 0);

    // Watchdog: kernel never produces output.
    do_reset();
    src_valid = 1; k_iready = 1; snk_ready = 1; kov_en = 0;
    issue_start(2, 8, s);
    run_until_end(40, 1);
    check("wd_err_cycle", st_err_cyc - s, 11);
    check("wd_busy_cycles", st_busy, 10);
    for (int i = 0; i < 3; i++) run_cycle();
    check("wd_err_sticky", err, 1);
    check("wd_no_done", st_done, 0);
    kov_en = 1;
    issue_start(1, 8, s);
    check("wd_err_clear", err, 0);
    run_until_end(20, 0);
    check("wd_rerun_done", st_done, 1);

    // Reset mid-run with in_count=2.
    do_reset();
    src_valid = 1; k_iready = 1; snk_ready = 0; kov_en = 1;
    issue_start(6, 0, s);
    for (int i = 0; i < 10 && in_count != 2; i++) run_cycle();
    check("rst_pre_in_count", in_count, 2);
    rst = 1;
    run_cycle();
    rst = 0;
    check("rst_in_count", in_count, 0);
    check("rst_out_count", out_count, 0);
    snk_ready = 1; k_ovalid = 1;
    #4;
    check("rst_gates", {busy, done, src_ready, k_ivalid, k_oready, snk_valid}, 6'b0);
    check("rst_no_done", st_done, 0);
    @(posedge clk);
    #1;

    // Random traffic against the reference model.
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      start     = ($urandom_range(0, 3) == 0);
      nitems    = CW'($urandom_range(0, 6));
      timeout   = TW'($urandom_range(0, 6));
      src_valid = ($urandom_range(0, 3) != 0);
      k_iready  = ($urandom_range(0, 3) != 0);
      snk_ready = ($urandom_range(0, 4) > 1);
      kov_en    = ($urandom_range(0, 9) > 2);
      rst       = ($urandom_range(0, 120) == 0);
      run_cycle();
    end
    rst = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
